// File: rtl/wb_regfile.sv
// Write-back register file: 32 integer registers (x0 = 0), ALU and load result
// ports, a pending-load FIFO that drains into idle write slots, and two bypassed read ports.
module wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_en,
    input  logic [4:0]        alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [4:0]        ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [4:0]        rs1_addr,
    input  logic [4:0]        rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              busy
);

    localparam int unsigned NREG  = 32;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = PTR_W + 1;

    typedef struct packed {
        logic              vld;
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [DATA_W-1:0] regs [NREG];
    entry_t            fifo [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic              aw;
    logic              la;
    logic              ld_keep;
    logic              fifo_empty;
    logic              head_vld;
    logic              pop;
    logic              ld_direct;
    logic              push;

    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic [4:0]        raddr [2];
    logic [DATA_W-1:0] rdata [2];
    logic [IDX_W-1:0]  idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Handshake and slot arbitration; a load killed by a same-cycle ALU write is still handshaken.
    assign aw         = !rst && alu_en && (alu_rd != 5'd0);
    assign ld_ready   = !rst && (count < CNT_W'(DEPTH));
    assign la         = ld_valid && ld_ready;
    assign ld_keep    = la && (ld_rd != 5'd0) && !(aw && (ld_rd == alu_rd));
    assign fifo_empty = (count == CNT_W'(0));
    assign head_vld   = fifo[rd_ptr].vld;
    assign pop        = !rst && !aw && !fifo_empty;
    // A stale head pops without using the slot, so a lone stale entry lets a new load go direct.
    assign ld_direct  = ld_keep && !aw &&
                        (fifo_empty || ((count == CNT_W'(1)) && !head_vld));
    assign push       = ld_keep && !ld_direct;
    assign busy       = !rst && !fifo_empty;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = 5'd0;
        wr_data = '0;
        if (aw) begin
            wr_en   = 1'b1;
            wr_addr = alu_rd;
            wr_data = alu_data;
        end else if (pop && head_vld) begin
            wr_en   = 1'b1;
            wr_addr = fifo[rd_ptr].rd;
            wr_data = fifo[rd_ptr].data;
        end else if (ld_direct) begin
            wr_en   = 1'b1;
            wr_addr = ld_rd;
            wr_data = ld_data;
        end
    end

    // Architectural register array.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Pending-load FIFO with WAW invalidation by ALU writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (aw && (fifo[i].rd == alu_rd)) begin
                    fifo[i].vld <= 1'b0;
                end
            end
            if (push) begin
                fifo[wr_ptr] <= '{vld: 1'b1, rd: ld_rd, data: ld_data};
                wr_ptr       <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign raddr[0] = rs1_addr;
    assign raddr[1] = rs2_addr;

    // Read bypass: later assignments are newer and override older sources.
    always_comb begin
        idx = '0;
        for (int p = 0; p < 2; p++) begin
            rdata[p] = regs[raddr[p]];
            for (int i = 0; i < int'(DEPTH); i++) begin
                idx = {1'b0, rd_ptr} + IDX_W'(i);
                if (idx >= IDX_W'(DEPTH)) begin
                    idx = idx - IDX_W'(DEPTH);
                end
                if ((i < int'(count)) && fifo[idx[PTR_W-1:0]].vld &&
                    (fifo[idx[PTR_W-1:0]].rd == raddr[p])) begin
                    rdata[p] = fifo[idx[PTR_W-1:0]].data;
                end
            end
            if (ld_keep && (ld_rd == raddr[p])) begin
                rdata[p] = ld_data;
            end
            if (aw && (alu_rd == raddr[p])) begin
                rdata[p] = alu_data;
            end
            if (rst || (raddr[p] == 5'd0)) begin
                rdata[p] = '0;
            end
        end
    end

    assign rs1_data = rdata[0];
    assign rs2_data = rdata[1];

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table, a reset-mid-drain sequence,
// then random traffic checked against a queue-based architectural model.
module tb_wb_regfile;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_en;
    logic [4:0]        alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [4:0]        ld_rd;
    logic [DATA_W-1:0] ld_data;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              busy;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .alu_en   (alu_en),
        .alu_rd   (alu_rd),
        .alu_data (alu_data),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_rd    (ld_rd),
        .ld_data  (ld_data),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .busy     (busy)
    );

    typedef struct {
        logic        rst;
        logic        ae;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        erdy;
        logic        ebusy;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          vld;
    } ment_t;

    vec_t        vecs[$];
    ment_t       mq[$];
    logic [31:0] mregs[32];
    int          errors = 0;
    int          checks = 0;

    function automatic vec_t mk(input logic r, input logic ae, input logic [4:0] ard,
                                input logic [31:0] ad, input logic lv, input logic [4:0] lrd,
                                input logic [31:0] ldd, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic erdy, input logic ebusy);
        vec_t v;
        v.rst = r; v.ae = ae; v.ard = ard; v.ad = ad;
        v.lv = lv; v.lrd = lrd; v.ldd = ldd; v.r1 = r1; v.r2 = r2;
        v.e1 = e1; v.e2 = e2; v.erdy = erdy; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.rst; alu_en = v.ae; alu_rd = v.ard; alu_data = v.ad;
        ld_valid = v.lv; ld_rd = v.lrd; ld_data = v.ldd;
        rs1_addr = v.r1; rs2_addr = v.r2;
        #1;
    endtask

    // Newest architectural value: array, then pending loads oldest..youngest, then this cycle's load, then ALU.
    function automatic logic [31:0] model_read(input vec_t v, input logic [4:0] a);
        logic [31:0] val;
        bit          mrdy;
        bit          keep;
        if (v.rst || a == 5'd0) return 32'h0;
        mrdy = (mq.size() < DEPTH);
        keep = v.lv && mrdy && v.lrd != 5'd0 && !(v.ae && v.ard != 5'd0 && v.ard == v.lrd);
        val = mregs[a];
        foreach (mq[i]) if (mq[i].vld && mq[i].rd == a) val = mq[i].data;
        if (keep && v.lrd == a) val = v.ldd;
        if (v.ae && v.ard != 5'd0 && v.ard == a) val = v.ad;
        return val;
    endfunction

    task automatic model_step(input vec_t v);
        bit    aw;
        bit    keep;
        bit    direct;
        int    was;
        bit    head_stale;
        ment_t e;
        if (v.rst) begin
            foreach (mregs[i]) mregs[i] = 32'h0;
            mq.delete();
            return;
        end
        aw         = v.ae && v.ard != 5'd0;
        keep       = v.lv && (mq.size() < DEPTH) && v.lrd != 5'd0 && !(aw && v.ard == v.lrd);
        was        = mq.size();
        head_stale = (was > 0) && !mq[0].vld;
        if (aw) begin
            mregs[v.ard] = v.ad;
            foreach (mq[i]) if (mq[i].rd == v.ard) mq[i].vld = 0;
        end else if (was > 0) begin
            e = mq.pop_front();
            if (e.vld) mregs[e.rd] = e.data;
        end
        direct = keep && !aw && (was == 0 || (was == 1 && head_stale));
        if (direct) begin
            mregs[v.lrd] = v.ldd;
        end else if (keep) begin
            e.rd = v.lrd; e.data = v.ldd; e.vld = 1;
            mq.push_back(e);
        end
    endtask

    task automatic model_cycle(input vec_t v, input string tag);
        logic [31:0] e1;
        logic [31:0] e2;
        logic        erdy;
        logic        ebusy;
        apply(v);
        e1    = model_read(v, v.r1);
        e2    = model_read(v, v.r2);
        erdy  = !v.rst && (mq.size() < DEPTH);
        ebusy = !v.rst && (mq.size() != 0);
        check({tag, "_rs1"}, rs1_data, e1);
        check({tag, "_rs2"}, rs2_data, e2);
        check({tag, "_ld_ready"}, 32'(ld_ready), 32'(erdy));
        check({tag, "_busy"}, 32'(busy), 32'(ebusy));
        model_step(v);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; alu_en = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0; rs1_addr = '0; rs2_addr = '0;
        foreach (mregs[i]) mregs[i] = 32'h0;

        //            rst ae ard ad            lv lrd ldd     r1  r2  e1            e2      rdy busy
        vecs.push_back(mk(1, 0, 0,  0,            0, 0,  0,      5,  0,  0,            0,      0, 0));
        vecs.push_back(mk(0, 1, 5,  'h1234,       0, 0,  0,      5,  0,  'h1234,       0,      1, 0));
        vecs.push_back(mk(1, 1, 6,  'h77,         1, 6,  'h78,   5,  6,  0,            0,      0, 0));
        vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,      5,  6,  0,            0,      1, 0));
        vecs.push_back(mk(0, 1, 7,  'hDEADBEEF,   0, 0,  0,      7,  5,  'hDEADBEEF,   0,      1, 0));
        vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,      7,  5,  'hDEADBEEF,   0,      1, 0));
        vecs.push_back(mk(0, 1, 3,  'h11,         1, 4,  'hAA,   3,  4,  'h11,         'hAA,   1, 0));
        vecs.push_back(mk(0, 1, 3,  'h22,         0, 0,  0,      3,  4,  'h22,         'hAA,   1, 1));
        vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,      4,  3,  'hAA,         'h22,   1, 1));
        vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,      4,  0,  'hAA,         0,      1, 0));
        vecs.push_back(mk(0, 1, 1,  'h101,        1, 8,  'h88,   8,  1,  'h88,         'h101,  1, 0));
        vecs.push_back(mk(0, 1, 1,  'h102,        1, 9,  'h99,   8,  9,  'h88,         'h99,   1, 1));
        vecs.push_back(mk(0, 1, 2,  'h103,        1, 10, 'hA0,   10, 9,  0,            'h99,   0, 1));
        vecs.push_back(mk(0, 1, 2,  'h104,        1, 11, 'hB0,   11, 2,  0,            'h104,  0, 1));
        vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,      8,  9,  'h88,         'h99,   0, 1));
        vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,      8,  9,  'h88,         'h99,   1, 1));
        vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,      9,  10, 'h99,         0,      1, 0));
        vecs.push_back(mk(0, 1, 1,  'h105,        1, 9,  'h55,   9,  1,  'h55,         'h105,  1, 0));
        vecs.push_back(mk(0, 1, 9,  'h66,         0, 0,  0,      9,  1,  'h66,         'h105,  1, 1));
        vecs.push_back(mk(0, 0, 0,  0,            1, 12, 'hC0,   9,  12, 'h66,         'hC0,   1, 1));
        vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,      9,  12, 'h66,         'hC0,   1, 0));
        vecs.push_back(mk(0, 1, 0,  'hFFFF,       1, 0,  'h1,    0,  0,  0,            0,      1, 0));
        vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,      0,  13, 0,            0,      1, 0));
        vecs.push_back(mk(0, 1, 13, 'h77,         1, 13, 'h33,   13, 0,  'h77,         0,      1, 0));
        vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,      13, 0,  'h77,         0,      1, 0));

        foreach (vecs[i]) begin
            apply(vecs[i]);
            check($sformatf("vec%0d_rs1", i), rs1_data, vecs[i].e1);
            check($sformatf("vec%0d_rs2", i), rs2_data, vecs[i].e2);
            check($sformatf("vec%0d_ld_ready", i), 32'(ld_ready), 32'(vecs[i].erdy));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].ebusy));
            model_step(vecs[i]);
        end

        // Reset while two loads are pending: both must be lost.
        model_cycle(mk(0, 1, 1, 'h201, 1, 20, 'h20, 20, 21, 0, 0, 0, 0), "drain0");
        model_cycle(mk(0, 1, 2, 'h202, 1, 21, 'h21, 20, 21, 0, 0, 0, 0), "drain1");
        model_cycle(mk(1, 0, 0, 0,     0, 0,  0,    20, 21, 0, 0, 0, 0), "drain_rst");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 20, 21, 0, 0, 0, 0));
        check("post_rst_x20", rs1_data, 32'h0);
        check("post_rst_x21", rs2_data, 32'h0);
        check("post_rst_ld_ready", 32'(ld_ready), 32'h1);
        check("post_rst_busy", 32'(busy), 32'h0);
        model_step(mk(0, 0, 0, 0, 0, 0, 0, 20, 21, 0, 0, 0, 0));

        for (int n = 0; n < 3000; n++) begin
            v.rst = ($urandom_range(0, 199) == 0);
            v.ae  = ($urandom_range(0, 99) < 50);
            v.ard = 5'($urandom_range(0, 7));
            v.ad  = $urandom;
            v.lv  = ($urandom_range(0, 99) < 60);
            v.lrd = 5'($urandom_range(0, 7));
            v.ldd = $urandom;
            v.r1  = 5'($urandom_range(0, 7));
            v.r2  = 5'($urandom_range(0, 7));
            v.e1 = '0; v.e2 = '0; v.erdy = 1'b0; v.ebusy = 1'b0;
            model_cycle(v, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
